thread_scheduler: RTL and testbench

Per-thread fetch scheduler for the multithreaded pipeline; picks which thread the IF stage fetches each cycle.
Tracks each thread's miss state (iTLB miss, icache miss) and masks threads the hazard unit blocks.
Grants eligible threads round-robin and drives the registered thread id into IF, which carries it down through ID/EX.
Also keeps an idle-cycle counter for performance monitoring.

---
 rtl/thread_scheduler_pkg.sv | 14 +
 rtl/thread_scheduler_rr_arbiter.sv | 37 +++
 rtl/thread_scheduler.sv | 90 +++++++++
 tb/tb_thread_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/thread_scheduler_pkg.sv
// Shared thread types for the multithreaded front end.
package common;

  localparam int n_threads = 4;

  typedef logic [$clog2(n_threads)-1:0] threadid_t;

  typedef enum logic [1:0] {
    T_READY   = 2'd0,
    T_TLBMISS = 2'd1,
    T_ICMISS  = 2'd2
  } thread_state_t;

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// Round-robin pick among requesting threads, starting just after last_grant.
// Latency: combinational. Backpressure: none, the caller decides whether to take the grant.
module rr_arbiter #(
  parameter int N_THREADS = 4,
  localparam int TID_W = $clog2(N_THREADS)
) (
  input  logic [N_THREADS-1:0] req,
  input  logic [TID_W-1:0]     last_grant,
  output logic                 gnt_valid,
  output logic [TID_W-1:0]     gnt_id
);

  logic [TID_W-1:0]     start;
  logic [TID_W-1:0]     off;
  logic [N_THREADS-1:0] rot;

  assign start = last_grant + TID_W'(1);

  // N_THREADS is a power of two, so TID_W-wide sums wrap modulo N_THREADS.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      rot[i] = req[TID_W'(i) + start];
    end
  end

  always_comb begin
    off = '0;
    for (int i = N_THREADS - 1; i >= 0; i--) begin
      if (rot[i]) off = TID_W'(i);
    end
  end

  assign gnt_valid = |req;
  assign gnt_id    = start + off;

endmodule

// File: rtl/thread_scheduler.sv
// Per-thread fetch scheduler: tracks miss state and grants eligible threads round-robin.
// Latency: grant registered at the end of the cycle it is computed. Backpressure: fetch_en=0 freezes grant and counter.
// Miss/fill state machines advance every cycle regardless of fetch_en.
module thread_scheduler
  import common::*;
#(
  parameter int N_THREADS = n_threads,
  parameter int TID_W     = $clog2(N_THREADS),
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic [N_THREADS-1:0] thread_en,
  input  logic [N_THREADS-1:0] hz_block,
  input  logic                 if_icache_miss,
  input  logic                 if_itlb_miss,
  input  logic [TID_W-1:0]     if_miss_thread,
  input  logic                 icache_fill,
  input  logic                 itlb_fill,
  input  logic [TID_W-1:0]     fill_thread,
  output logic [TID_W-1:0]     if_thread,
  output logic                 if_valid,
  output logic [N_THREADS-1:0] ready_mask,
  output logic [CNT_W-1:0]     idle_cycles
);

  logic [N_THREADS-1:0] eligible;
  logic [TID_W-1:0]     last_grant;
  logic                 gnt_valid;
  logic [TID_W-1:0]     gnt_id;

  for (genvar t = 0; t < N_THREADS; t++) begin : g_thr
    localparam logic [TID_W-1:0] TID = TID_W'(t);

    thread_state_t state;
    logic          miss_hit;
    logic          fill_hit;

    assign miss_hit = (if_miss_thread == TID);
    assign fill_hit = (fill_thread == TID);

    assign ready_mask[t] = (state == T_READY);
    // A miss reported this cycle already disqualifies the thread from this cycle's grant.
    assign eligible[t]   = ready_mask[t] & thread_en[t] & ~hz_block[t]
                         & ~((if_icache_miss | if_itlb_miss) & miss_hit);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= T_READY;
      end else begin
        case (state)
          T_READY: begin
            if (if_itlb_miss && miss_hit)        state <= T_TLBMISS;
            else if (if_icache_miss && miss_hit) state <= T_ICMISS;
          end
          T_TLBMISS: if (itlb_fill && fill_hit)   state <= T_READY;
          T_ICMISS:  if (icache_fill && fill_hit) state <= T_READY;
          default:                                state <= T_READY;
        endcase
      end
    end
  end

  rr_arbiter #(.N_THREADS(N_THREADS)) u_rr (
    .req        (eligible),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_thread   <= '0;
      if_valid    <= 1'b0;
      last_grant  <= TID_W'(N_THREADS - 1);
      idle_cycles <= '0;
    end else if (fetch_en) begin
      if (gnt_valid) begin
        if_thread  <= gnt_id;
        if_valid   <= 1'b1;
        last_grant <= gnt_id;
      end else begin
        if_valid    <= 1'b0;
        idle_cycles <= idle_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// Randomized and directed bench for thread_scheduler with a queue-based scoreboard.
module tb_thread_scheduler;
  import common::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [3:0]  thread_en;
  logic [3:0]  hz_block;
  logic        if_icache_miss;
  logic        if_itlb_miss;
  logic [1:0]  if_miss_thread;
  logic        icache_fill;
  logic        itlb_fill;
  logic [1:0]  fill_thread;
  logic [1:0]  if_thread;
  logic        if_valid;
  logic [3:0]  ready_mask;
  logic [31:0] idle_cycles;

  always #5 clk = ~clk;

  thread_scheduler #(.N_THREADS(N), .TID_W(2), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .thread_en      (thread_en),
    .hz_block       (hz_block),
    .if_icache_miss (if_icache_miss),
    .if_itlb_miss   (if_itlb_miss),
    .if_miss_thread (if_miss_thread),
    .icache_fill    (icache_fill),
    .itlb_fill      (itlb_fill),
    .fill_thread    (fill_thread),
    .if_thread      (if_thread),
    .if_valid       (if_valid),
    .ready_mask     (ready_mask),
    .idle_cycles    (idle_cycles)
  );

  typedef struct {
    logic        v;
    logic [1:0]  th;
    logic [31:0] idle;
    logic [3:0]  rm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = ready, 1 = waiting on iTLB, 2 = waiting on icache.
  int          ms[N];
  int          mlast;
  logic [1:0]  mth;
  logic        mv;
  logic [31:0] midle;

  task automatic model_reset();
    for (int t = 0; t < N; t++) ms[t] = 0;
    mlast = N - 1;
    mth   = 2'd0;
    mv    = 1'b0;
    midle = 32'd0;
  endtask

  function automatic logic [3:0] model_rm();
    logic [3:0] r;
    for (int t = 0; t < N; t++) r[t] = (ms[t] == 0);
    return r;
  endfunction

  task automatic drive(input logic fe, input logic [3:0] en, input logic [3:0] hz,
                       input logic icm, input logic itm, input logic [1:0] mt,
                       input logic icf, input logic itf, input logic [1:0] ft);
    exp_t e;
    int   w;
    int   t;
    @(negedge clk);
    fetch_en = fe; thread_en = en; hz_block = hz;
    if_icache_miss = icm; if_itlb_miss = itm; if_miss_thread = mt;
    icache_fill = icf; itlb_fill = itf; fill_thread = ft;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      t = (mlast + k) % N;
      if (w < 0 && ms[t] == 0 && en[t] && !hz[t] && !((icm || itm) && mt == t)) w = t;
    end
    if (fe) begin
      if (w >= 0) begin
        mth = 2'(w); mv = 1'b1; mlast = w;
      end else begin
        mv = 1'b0; midle = midle + 32'd1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (ms[i] == 0) begin
        if (itm && mt == i)      ms[i] = 1;
        else if (icm && mt == i) ms[i] = 2;
      end else if (ms[i] == 1 && itf && ft == i) ms[i] = 0;
      else if (ms[i] == 2 && icf && ft == i)     ms[i] = 0;
    end
    e.v = mv; e.th = mth; e.idle = midle; e.rm = model_rm();
    q.push_back(e);
  endtask

  task automatic quiet(input logic fe, input logic [3:0] en, input logic [3:0] hz);
    drive(fe, en, hz, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic icf, input logic [1:0] ft);
    @(negedge clk);
    #2;
    rst = 1'b1;
    fetch_en = 1'b0; thread_en = 4'hf; hz_block = 4'h0;
    if_icache_miss = 1'b0; if_itlb_miss = 1'b0; if_miss_thread = 2'd0;
    itlb_fill = 1'b0; icache_fill = icf; fill_thread = ft;
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_ready_mask", 32'(ready_mask), 32'hf);
    chk("rst_if_thread", 32'(if_thread), 32'd0);
    chk("rst_idle", idle_cycles, 32'd0);
    q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    icache_fill = 1'b0;
  endtask

  // Monitor: every non-reset cycle with an outstanding expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        chk("sb_if_valid", 32'(if_valid), 32'(e.v));
        chk("sb_if_thread", 32'(if_thread), 32'(e.th));
        chk("sb_idle", idle_cycles, e.idle);
        chk("sb_ready_mask", 32'(ready_mask), 32'(e.rm));
      end
    end
  end

  initial begin
    logic [1:0]  sv_th;
    logic        sv_v;
    logic [31:0] sv_idle;
    logic [3:0]  en;
    logic [3:0]  hz;

    rst = 1'b1;
    fetch_en = 1'b0; thread_en = 4'h0; hz_block = 4'h0;
    if_icache_miss = 1'b0; if_itlb_miss = 1'b0; if_miss_thread = 2'd0;
    icache_fill = 1'b0; itlb_fill = 1'b0; fill_thread = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Plain rotation from reset.
    for (int i = 0; i < 5; i++) begin
      quiet(1'b1, 4'hf, 4'h0);
      settle();
      chk("rr_seq_thread", 32'(if_thread), 32'(i % N));
      chk("rr_seq_valid", 32'(if_valid), 32'd1);
    end

    // Icache miss on thread 1 in cycle 2, fill in cycle 10.
    do_reset(1'b0, 2'd0);
    for (int c = 0; c < 14; c++) begin
      drive(1'b1, 4'hf, 4'h0, c == 2, 1'b0, 2'd1, c == 10, 1'b0, 2'd1);
      settle();
      if (c >= 2 && c <= 10) chk("icmiss_skip_t1", 32'(if_thread == 2'd1), 32'd0);
      if (c >= 2 && c <= 9)  chk("icmiss_ready_mask", 32'(ready_mask), 32'hd);
      if (c == 10)           chk("icfill_ready_mask", 32'(ready_mask), 32'hf);
      if (c == 11)           chk("icfill_regrant_t1", 32'(if_thread), 32'd1);
    end

    // Both miss flags on thread 2: iTLB wins, only an iTLB fill restores it.
    do_reset(1'b0, 2'd0);
    drive(1'b1, 4'hf, 4'h0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
    settle();
    chk("dual_miss_mask", 32'(ready_mask), 32'hb);
    drive(1'b1, 4'hf, 4'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2);
    settle();
    chk("wrong_fill_ignored", 32'(ready_mask), 32'hb);
    drive(1'b1, 4'hf, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2);
    settle();
    chk("itlb_fill_restores", 32'(ready_mask), 32'hf);

    // All threads blocked for five cycles.
    do_reset(1'b0, 2'd0);
    quiet(1'b1, 4'hf, 4'h0);
    quiet(1'b1, 4'hf, 4'h0);
    repeat (5) quiet(1'b1, 4'hf, 4'hf);
    settle();
    chk("hz_idle_count", idle_cycles, 32'd5);
    chk("hz_if_valid", 32'(if_valid), 32'd0);
    chk("hz_if_thread_hold", 32'(if_thread), 32'd1);
    quiet(1'b1, 4'hf, 4'h0);
    settle();
    chk("hz_release_thread", 32'(if_thread), 32'd2);
    chk("hz_release_valid", 32'(if_valid), 32'd1);

    // Fill lands while the front end is frozen.
    drive(1'b1, 4'hf, 4'h0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0);
    settle();
    sv_th = mth; sv_v = mv; sv_idle = midle;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 4'hf, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, c == 1, 2'd3);
      settle();
      chk("frz_if_thread", 32'(if_thread), 32'(sv_th));
      chk("frz_if_valid", 32'(if_valid), 32'(sv_v));
      chk("frz_idle", idle_cycles, sv_idle);
    end
    chk("frz_state_restored", 32'(ready_mask), 32'hf);
    quiet(1'b1, 4'h8, 4'h0);
    settle();
    chk("frz_resume_thread", 32'(if_thread), 32'd3);
    chk("frz_resume_valid", 32'(if_valid), 32'd1);

    // Reset with threads 0 and 3 in icache miss, then a stale fill for 3.
    do_reset(1'b0, 2'd0);
    drive(1'b1, 4'hf, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 4'hf, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 2'd0);
    settle();
    chk("pre_rst_mask", 32'(ready_mask), 32'h6);
    do_reset(1'b1, 2'd3);
    drive(1'b1, 4'hf, 4'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3);
    settle();
    chk("post_rst_thread", 32'(if_thread), 32'd0);
    chk("post_rst_valid", 32'(if_valid), 32'd1);
    chk("post_rst_mask", 32'(ready_mask), 32'hf);

    // Random traffic against the reference model.
    do_reset(1'b0, 2'd0);
    for (int c = 0; c < 1500; c++) begin
      for (int t = 0; t < N; t++) begin
        en[t] = ($urandom_range(0, 7) != 0);
        hz[t] = ($urandom_range(0, 4) == 0);
      end
      drive($urandom_range(0, 9) != 0, en, hz,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
    end
    settle();
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
